keypad_matrix_scanner: RTL and testbench

Scans the 4x4 membrane keypad on the lock board and delivers one debounced, decoded key event per physical press. It drives the keypad rows (`matricial_lin`) and samples the columns (`matricial_col`). It produces the `key_code` / `key_valid` pair consumed by the doorlock controller's PIN-entry logic. It sits directly upstream of the lock FSM, on the same 50 MHz clock.

---
 rtl/keypad_matrix_scanner.sv | 173 +++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scanner.sv
// 4x4 membrane keypad scanner: row drive, column sampling, debounce and key decode.
// Emits one key_valid pulse per debounced press, with no auto-repeat.
module keypad_matrix_scanner #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] matricial_col,
  output logic [3:0] matricial_lin,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {StIdle, StDebounce, StHeld} state_e;

  logic [3:0]      col_s1_q, col_s2_q;
  logic [DivW-1:0] div_q;
  logic [1:0]      row_q;
  logic [15:0]     snap_q;
  state_e          state_q;
  logic [CntW-1:0] cnt_q, rel_cnt_q;
  logic [3:0]      cand_q;
  logic [3:0]      key_code_q;
  logic            key_valid_q, key_held_q;

  logic        capture, scan_done;
  logic [15:0] snap_full;
  logic [4:0]  n_keys;
  logic [3:0]  hit_idx;
  logic [3:0]  scan_code;
  logic        is_none, is_single;

  function automatic logic [3:0] key_lut(input logic [3:0] idx);
    unique case (idx)
      4'd0:  key_lut = 4'h1;
      4'd1:  key_lut = 4'h2;
      4'd2:  key_lut = 4'h3;
      4'd3:  key_lut = 4'hA;
      4'd4:  key_lut = 4'h4;
      4'd5:  key_lut = 4'h5;
      4'd6:  key_lut = 4'h6;
      4'd7:  key_lut = 4'hB;
      4'd8:  key_lut = 4'h7;
      4'd9:  key_lut = 4'h8;
      4'd10: key_lut = 4'h9;
      4'd11: key_lut = 4'hC;
      4'd12: key_lut = 4'hE;
      4'd13: key_lut = 4'h0;
      4'd14: key_lut = 4'hF;
      default: key_lut = 4'hD;
    endcase
  endfunction

  assign capture   = (div_q == DivLast);
  assign scan_done = capture && (row_q == 2'd3);

  // Merge the row being captured this cycle so row 3 is classified with the rest.
  always_comb begin
    snap_full = snap_q;
    if (capture) snap_full[{row_q, 2'b00} +: 4] = ~col_s2_q;
  end

  always_comb begin
    n_keys  = '0;
    hit_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap_full[i]) begin
        n_keys  = n_keys + 5'd1;
        hit_idx = 4'(i);
      end
    end
  end

  assign is_none   = (n_keys == 5'd0);
  assign is_single = (n_keys == 5'd1);
  assign scan_code = key_lut(hit_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
      div_q    <= '0;
      row_q    <= '0;
      snap_q   <= '0;
    end else begin
      col_s1_q <= matricial_col;
      col_s2_q <= col_s1_q;
      if (capture) begin
        div_q  <= '0;
        row_q  <= row_q + 2'd1;
        snap_q <= scan_done ? '0 : snap_full;
      end else begin
        div_q <= div_q + DivW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rel_cnt_q   <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (scan_done) begin
        unique case (state_q)
          StIdle: begin
            if (is_single) begin
              cand_q <= scan_code;
              cnt_q  <= CntW'(1);
              if (DEBOUNCE_SCANS == 1) begin
                key_code_q  <= scan_code;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                rel_cnt_q   <= '0;
                state_q     <= StHeld;
              end else begin
                state_q <= StDebounce;
              end
            end
          end
          StDebounce: begin
            if (is_single && scan_code == cand_q) begin
              cnt_q <= cnt_q + CntW'(1);
              if (cnt_q + CntW'(1) == CntLast) begin
                key_code_q  <= cand_q;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                rel_cnt_q   <= '0;
                state_q     <= StHeld;
              end
            end else begin
              cnt_q   <= '0;
              state_q <= StIdle;
            end
          end
          StHeld: begin
            if (is_none) begin
              if (rel_cnt_q + CntW'(1) == CntLast) begin
                rel_cnt_q  <= '0;
                cnt_q      <= '0;
                key_held_q <= 1'b0;
                state_q    <= StIdle;
              end else begin
                rel_cnt_q <= rel_cnt_q + CntW'(1);
              end
            end else begin
              rel_cnt_q <= '0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign matricial_lin = ~(4'b0001 << row_q);
  assign key_code      = key_code_q;
  assign key_valid     = key_valid_q;
  assign key_held      = key_held_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a keypad model driven per scan, checked every cycle
// against a scan-level reference of the press/release debounce rules.
module tb_keypad_matrix_scanner;

  localparam int unsigned SD   = 8;
  localparam int unsigned DS   = 3;
  localparam int unsigned SCAN = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col;
  logic [3:0]  lin;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = '0;

  string layout = "123A456B789C*0#D";

  int          total = 0;
  int          bad   = 0;
  int          pulses = 0;
  int          n = 0;
  bit          m_held, m_valid;
  int          m_run, m_rel;
  logic [3:0]  m_cand, m_code;

  always #5 clk = ~clk;

  keypad_matrix_scanner #(
    .SCAN_DIV      (SD),
    .DEBOUNCE_SCANS(DS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .matricial_col(col),
    .matricial_lin(lin),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_held     (key_held)
  );

  // Keypad: a pressed key shorts its column to its row while that row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!lin[r] && pressed[r*4+c]) col[c] = 1'b0;
  end

  function automatic logic [3:0] code_of(input byte ch);
    if (ch >= "0" && ch <= "9") return 4'(ch - "0");
    if (ch >= "A" && ch <= "D") return 4'(ch - "A" + 10);
    if (ch == "*") return 4'hE;
    return 4'hF;
  endfunction

  function automatic logic [15:0] keys(input string s);
    logic [15:0] m = '0;
    for (int i = 0; i < s.len(); i++)
      for (int k = 0; k < 16; k++)
        if (layout[k] == s[i]) m[k] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held = 0; m_valid = 0; m_run = 0; m_rel = 0; m_cand = '0; m_code = '0;
  endtask

  // One scan's worth of keys, already constant over the whole scan.
  task automatic scan_event();
    int cnt;
    logic [3:0] code;
    cnt  = $countones(pressed);
    code = '0;
    for (int k = 0; k < 16; k++) if (pressed[k]) code = code_of(layout[k]);
    if (!m_held) begin
      if (cnt == 1 && m_run > 0 && code == m_cand) m_run++;
      else if (cnt == 1 && m_run == 0) begin m_run = 1; m_cand = code; end
      else m_run = 0;
      if (m_run == int'(DS)) begin
        m_valid = 1; m_code = m_cand; m_held = 1; m_rel = 0; m_run = 0;
      end
    end else if (cnt == 0) begin
      m_rel++;
      if (m_rel == int'(DS)) begin m_held = 0; m_rel = 0; end
    end else begin
      m_rel = 0;
    end
  endtask

  task automatic step();
    logic [3:0] exp_lin;
    @(posedge clk); #1;
    n++;
    m_valid = 0;
    if (n % SCAN == 0) scan_event();
    if (key_valid) pulses++;
    exp_lin = ~(4'b0001 << ((n / SD) % 4));
    chk("lin", lin, exp_lin);
    chk("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
    chk("key_code", key_code, m_code);
    chk("key_held", {3'b0, key_held}, {3'b0, m_held});
  endtask

  task automatic run_scans(input logic [15:0] mask, input int count);
    pressed = mask;
    repeat (count * SCAN) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_lin", lin, 4'b1110);
      chk("rst_code", key_code, 4'h0);
      chk("rst_valid", {3'b0, key_valid}, 4'h0);
      chk("rst_held", {3'b0, key_held}, 4'h0);
    end
    rst = 1'b0;
    n = 0;
    model_reset();
  endtask

  initial begin
    int p0;
    int unsigned r;
    logic [15:0] cur;
    model_reset();

    do_reset();
    run_scans('0, 2);

    p0 = pulses;
    run_scans(keys("5"), 10);
    run_scans('0, 4);
    chk("press5_pulses", 4'(pulses - p0), 4'd1);
    chk("press5_code", key_code, 4'h5);

    p0 = pulses;
    run_scans(keys("#"), 1);
    run_scans('0, 1);
    run_scans(keys("#"), 1);
    run_scans('0, 1);
    chk("bounce_no_pulse", 4'(pulses - p0), 4'd0);
    run_scans(keys("#"), 4);
    run_scans('0, 4);
    chk("bounce_pulses", 4'(pulses - p0), 4'd1);
    chk("bounce_code", key_code, 4'hF);

    p0 = pulses;
    run_scans(keys("12"), 6);
    run_scans('0, 2);
    run_scans(keys("D"), 2);
    run_scans('0, 2);
    chk("chord_short_pulses", 4'(pulses - p0), 4'd0);
    chk("chord_short_code", key_code, 4'hF);

    p0 = pulses;
    run_scans(keys("7"), 4);
    run_scans(keys("78"), 3);
    run_scans(keys("8"), 2);
    run_scans('0, 4);
    chk("held_change_pulses", 4'(pulses - p0), 4'd1);
    chk("held_change_code", key_code, 4'h7);
    run_scans(keys("8"), 4);
    run_scans('0, 4);
    chk("press8_code", key_code, 4'h8);

    run_scans(keys("*"), 5);
    do_reset();
    p0 = pulses;
    run_scans(keys("*"), 4);
    chk("rst_held_pulses", 4'(pulses - p0), 4'd1);
    chk("rst_held_code", key_code, 4'hE);
    run_scans('0, 4);

    cur = '0;
    repeat (40) begin
      r = $urandom_range(0, 99);
      if (r < 55) cur = cur;
      else if (r < 75) cur = '0;
      else if (r < 93) cur = 16'(1) << $urandom_range(0, 15);
      else cur = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      run_scans(cur, 1);
    end
    run_scans('0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
